spi_master_apb_regif_stall: RTL and testbench

- Next-generation APB register front-end for the SPI master, placed between the APB interconnect and the SPI controller/FIFO core.
- Carries the existing control, length and dummy registers, with these changes:
  - chip-select count and clock-divider width are set by parameters;
  - TX/RX FIFO accesses are flow-controlled with PREADY wait states and an error on timeout;
  - interrupt status is sticky (write-1-to-clear) and maskable;
  - unmapped accesses return an error response.

---
 rtl/spi_master_apb_regif_stall.sv | 331 +++++++++++++++++++++++++++++++++
 tb/tb_spi_master_apb_regif_stall.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_apb_regif_stall.sv
// APB register front-end for the SPI master core.
// Register accesses complete with zero wait states. TX/RX FIFO accesses hold
// PREADY low until the core handshakes, or end with an error when the stall
// timeout expires.
module spi_master_apb_regif_stall #(
  parameter int BUFFER_DEPTH      = 10,
  parameter int APB_ADDR_WIDTH    = 12,
  parameter int NUM_CS            = 4,
  parameter int CLKDIV_WIDTH      = 16,
  parameter int STALL_TIMEOUT     = 255,
  localparam int LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0]   PADDR,
  input  logic [31:0]                 PWDATA,
  input  logic                        PWRITE,
  input  logic                        PSEL,
  input  logic                        PENABLE,
  output logic [31:0]                 PRDATA,
  output logic                        PREADY,
  output logic                        PSLVERR,
  input  logic [31:0]                 spi_status,
  output logic [CLKDIV_WIDTH-1:0]     spi_clk_div,
  output logic                        spi_clk_div_valid,
  output logic [31:0]                 spi_cmd,
  output logic [31:0]                 spi_addr,
  output logic [5:0]                  spi_cmd_len,
  output logic [5:0]                  spi_addr_len,
  output logic [15:0]                 spi_data_len,
  output logic [15:0]                 spi_dummy_rd,
  output logic [15:0]                 spi_dummy_wr,
  output logic [NUM_CS-1:0]           spi_csreg,
  output logic                        spi_rd,
  output logic                        spi_wr,
  output logic                        spi_qrd,
  output logic                        spi_qwr,
  output logic                        spi_swrst,
  output logic [LOG_BUFFER_DEPTH:0]   spi_int_th_tx,
  output logic [LOG_BUFFER_DEPTH:0]   spi_int_th_rx,
  output logic [31:0]                 spi_data_tx,
  output logic                        spi_data_tx_valid,
  input  logic                        spi_data_tx_ready,
  input  logic [31:0]                 spi_data_rx,
  input  logic                        spi_data_rx_valid,
  output logic                        spi_data_rx_ready,
  input  logic                        evt_tx_th,
  input  logic                        evt_rx_th,
  input  logic                        evt_eot,
  output logic                        spi_irq
);

  localparam int TH_W  = LOG_BUFFER_DEPTH + 1;
  localparam int CNT_W = $clog2(STALL_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_TIMEOUT);

  localparam logic [3:0] A_CTRL   = 4'd0;
  localparam logic [3:0] A_CLKDIV = 4'd1;
  localparam logic [3:0] A_CMD    = 4'd2;
  localparam logic [3:0] A_ADDR   = 4'd3;
  localparam logic [3:0] A_LEN    = 4'd4;
  localparam logic [3:0] A_DUM    = 4'd5;
  localparam logic [3:0] A_TXFIFO = 4'd6;
  localparam logic [3:0] A_RXFIFO = 4'd8;
  localparam logic [3:0] A_INTCFG = 4'd9;
  localparam logic [3:0] A_INTSTA = 4'd10;

  typedef enum logic [1:0] {ST_IDLE, ST_TX_WAIT, ST_RX_WAIT} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CLKDIV_WIDTH-1:0]   clk_div_q, clk_div_d;
  logic                      clk_div_valid_q, clk_div_valid_d;
  logic [31:0]               cmd_q, cmd_d;
  logic [31:0]               addr_q, addr_d;
  logic [5:0]                cmd_len_q, cmd_len_d;
  logic [5:0]                addr_len_q, addr_len_d;
  logic [15:0]               data_len_q, data_len_d;
  logic [15:0]               dummy_rd_q, dummy_rd_d;
  logic [15:0]               dummy_wr_q, dummy_wr_d;
  logic [NUM_CS-1:0]         csreg_q, csreg_d;
  logic [4:0]                cmd_pulse_q, cmd_pulse_d;
  logic [TH_W-1:0]           th_tx_q, th_tx_d;
  logic [TH_W-1:0]           th_rx_q, th_rx_d;
  logic [2:0]                mask_q, mask_d;
  logic [3:0]                intsta_q, intsta_d;
  logic                      irq_q, irq_d;

  logic [3:0]                reg_addr;
  logic                      apb_access;
  logic                      wr_ok, rd_ok, apb_err;
  logic                      tx_req, rx_req;
  logic                      reg_we;
  logic                      fifo_timeout;
  logic [3:0]                intsta_clr;

  // Address decode: which accesses are legal for the selected register.
  always_comb begin
    reg_addr   = PADDR[5:2];
    apb_access = PSEL & PENABLE;
    wr_ok      = 1'b0;
    rd_ok      = 1'b0;
    case (reg_addr)
      A_CTRL, A_CLKDIV, A_CMD, A_ADDR, A_LEN, A_DUM, A_INTCFG, A_INTSTA: begin
        wr_ok = 1'b1;
        rd_ok = 1'b1;
      end
      A_TXFIFO: wr_ok = 1'b1;
      A_RXFIFO: rd_ok = 1'b1;
      default:  ;
    endcase
    apb_err = apb_access & (PWRITE ? ~wr_ok : ~rd_ok);
    tx_req  = apb_access &  PWRITE & (reg_addr == A_TXFIFO);
    rx_req  = apb_access & ~PWRITE & (reg_addr == A_RXFIFO);
  end

  // FIFO stall FSM: drives PREADY/PSLVERR and the FIFO handshake signals.
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    PREADY            = 1'b1;
    PSLVERR           = 1'b0;
    spi_data_tx_valid = 1'b0;
    spi_data_rx_ready = 1'b0;
    fifo_timeout      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (tx_req) begin
          spi_data_tx_valid = 1'b1;
          if (!spi_data_tx_ready) begin
            // The IDLE access cycle already counts as the first wait cycle.
            PREADY  = 1'b0;
            state_d = ST_TX_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end else if (rx_req) begin
          spi_data_rx_ready = 1'b1;
          if (!spi_data_rx_valid) begin
            PREADY  = 1'b0;
            state_d = ST_RX_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end else if (apb_err) begin
          PSLVERR = 1'b1;
        end
      end
      ST_TX_WAIT, ST_RX_WAIT: begin
        if (!apb_access) begin
          // Master abandoned the transfer: drop back without moving data.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          PSLVERR      = 1'b1;
          fifo_timeout = 1'b1;
          state_d      = ST_IDLE;
          cnt_d        = '0;
        end else if (state_q == ST_TX_WAIT) begin
          spi_data_tx_valid = 1'b1;
          if (spi_data_tx_ready) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            PREADY = 1'b0;
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end else begin
          spi_data_rx_ready = 1'b1;
          if (spi_data_rx_valid) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            PREADY = 1'b0;
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Register writes, command pulses and sticky interrupt status.
  always_comb begin
    reg_we          = (state_q == ST_IDLE) & apb_access & PWRITE;
    clk_div_d       = clk_div_q;
    clk_div_valid_d = 1'b0;
    cmd_d           = cmd_q;
    addr_d          = addr_q;
    cmd_len_d       = cmd_len_q;
    addr_len_d      = addr_len_q;
    data_len_d      = data_len_q;
    dummy_rd_d      = dummy_rd_q;
    dummy_wr_d      = dummy_wr_q;
    csreg_d         = csreg_q;
    cmd_pulse_d     = '0;
    th_tx_d         = th_tx_q;
    th_rx_d         = th_rx_q;
    mask_d          = mask_q;
    intsta_clr      = '0;
    if (reg_we) begin
      case (reg_addr)
        A_CTRL: begin
          cmd_pulse_d = PWDATA[4:0];
          csreg_d     = PWDATA[8 +: NUM_CS];
        end
        A_CLKDIV: begin
          clk_div_d       = PWDATA[CLKDIV_WIDTH-1:0];
          clk_div_valid_d = 1'b1;
        end
        A_CMD:  cmd_d  = PWDATA;
        A_ADDR: addr_d = PWDATA;
        A_LEN: begin
          cmd_len_d  = PWDATA[5:0];
          addr_len_d = PWDATA[13:8];
          data_len_d = PWDATA[31:16];
        end
        A_DUM: begin
          dummy_rd_d = PWDATA[15:0];
          dummy_wr_d = PWDATA[31:16];
        end
        A_INTCFG: begin
          th_tx_d = PWDATA[TH_W-1:0];
          th_rx_d = PWDATA[8 +: TH_W];
          mask_d  = PWDATA[18:16];
        end
        A_INTSTA: intsta_clr = PWDATA[3:0];
        default:  ;
      endcase
    end
    // A set in the same cycle as its clear wins.
    intsta_d = (intsta_q & ~intsta_clr) | {fifo_timeout, evt_eot, evt_rx_th, evt_tx_th};
    irq_d    = (|(intsta_q[2:0] & mask_q)) | intsta_q[3];
  end

  // Read mux; errored and timed-out accesses return zero.
  always_comb begin
    PRDATA = '0;
    if (apb_access && !PWRITE && !apb_err) begin
      case (reg_addr)
        A_CTRL:   PRDATA = spi_status;
        A_CLKDIV: PRDATA[CLKDIV_WIDTH-1:0] = clk_div_q;
        A_CMD:    PRDATA = cmd_q;
        A_ADDR:   PRDATA = addr_q;
        A_LEN: begin
          PRDATA[5:0]   = cmd_len_q;
          PRDATA[13:8]  = addr_len_q;
          PRDATA[31:16] = data_len_q;
        end
        A_DUM: begin
          PRDATA[15:0]  = dummy_rd_q;
          PRDATA[31:16] = dummy_wr_q;
        end
        A_RXFIFO: PRDATA = fifo_timeout ? 32'd0 : spi_data_rx;
        A_INTCFG: begin
          PRDATA[TH_W-1:0]  = th_tx_q;
          PRDATA[8 +: TH_W] = th_rx_q;
          PRDATA[18:16]     = mask_q;
        end
        A_INTSTA: PRDATA[3:0] = intsta_q;
        default:  ;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      clk_div_q       <= '0;
      clk_div_valid_q <= 1'b0;
      cmd_q           <= '0;
      addr_q          <= '0;
      cmd_len_q       <= '0;
      addr_len_q      <= '0;
      data_len_q      <= '0;
      dummy_rd_q      <= '0;
      dummy_wr_q      <= '0;
      csreg_q         <= '0;
      cmd_pulse_q     <= '0;
      th_tx_q         <= '0;
      th_rx_q         <= '0;
      mask_q          <= '0;
      intsta_q        <= '0;
      irq_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      clk_div_q       <= clk_div_d;
      clk_div_valid_q <= clk_div_valid_d;
      cmd_q           <= cmd_d;
      addr_q          <= addr_d;
      cmd_len_q       <= cmd_len_d;
      addr_len_q      <= addr_len_d;
      data_len_q      <= data_len_d;
      dummy_rd_q      <= dummy_rd_d;
      dummy_wr_q      <= dummy_wr_d;
      csreg_q         <= csreg_d;
      cmd_pulse_q     <= cmd_pulse_d;
      th_tx_q         <= th_tx_d;
      th_rx_q         <= th_rx_d;
      mask_q          <= mask_d;
      intsta_q        <= intsta_d;
      irq_q           <= irq_d;
    end
  end

  assign spi_clk_div       = clk_div_q;
  assign spi_clk_div_valid = clk_div_valid_q;
  assign spi_cmd           = cmd_q;
  assign spi_addr          = addr_q;
  assign spi_cmd_len       = cmd_len_q;
  assign spi_addr_len      = addr_len_q;
  assign spi_data_len      = data_len_q;
  assign spi_dummy_rd      = dummy_rd_q;
  assign spi_dummy_wr      = dummy_wr_q;
  assign spi_csreg         = csreg_q;
  assign spi_rd            = cmd_pulse_q[0];
  assign spi_wr            = cmd_pulse_q[1];
  assign spi_qrd           = cmd_pulse_q[2];
  assign spi_qwr           = cmd_pulse_q[3];
  assign spi_swrst         = cmd_pulse_q[4];
  assign spi_int_th_tx     = th_tx_q;
  assign spi_int_th_rx     = th_rx_q;
  assign spi_data_tx       = PWDATA;
  assign spi_irq           = irq_q;

endmodule

// File: tb/tb_spi_master_apb_regif_stall.sv
// Scoreboard bench for the SPI master APB register front-end.
module tb_spi_master_apb_regif_stall;

  localparam int ST = 8;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] spi_status;
  logic [15:0] spi_clk_div;
  logic        spi_clk_div_valid;
  logic [31:0] spi_cmd, spi_addr;
  logic [5:0]  spi_cmd_len, spi_addr_len;
  logic [15:0] spi_data_len, spi_dummy_rd, spi_dummy_wr;
  logic [3:0]  spi_csreg;
  logic        spi_rd, spi_wr, spi_qrd, spi_qwr, spi_swrst;
  logic [4:0]  spi_int_th_tx, spi_int_th_rx;
  logic [31:0] spi_data_tx;
  logic        spi_data_tx_valid, spi_data_tx_ready;
  logic [31:0] spi_data_rx;
  logic        spi_data_rx_valid, spi_data_rx_ready;
  logic        evt_tx_th, evt_rx_th, evt_eot;
  logic        spi_irq;

  spi_master_apb_regif_stall #(.STALL_TIMEOUT(ST)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .spi_status(spi_status),
    .spi_clk_div(spi_clk_div), .spi_clk_div_valid(spi_clk_div_valid),
    .spi_cmd(spi_cmd), .spi_addr(spi_addr), .spi_cmd_len(spi_cmd_len),
    .spi_addr_len(spi_addr_len), .spi_data_len(spi_data_len),
    .spi_dummy_rd(spi_dummy_rd), .spi_dummy_wr(spi_dummy_wr),
    .spi_csreg(spi_csreg), .spi_rd(spi_rd), .spi_wr(spi_wr), .spi_qrd(spi_qrd),
    .spi_qwr(spi_qwr), .spi_swrst(spi_swrst), .spi_int_th_tx(spi_int_th_tx),
    .spi_int_th_rx(spi_int_th_rx), .spi_data_tx(spi_data_tx),
    .spi_data_tx_valid(spi_data_tx_valid), .spi_data_tx_ready(spi_data_tx_ready),
    .spi_data_rx(spi_data_rx), .spi_data_rx_valid(spi_data_rx_valid),
    .spi_data_rx_ready(spi_data_rx_ready), .evt_tx_th(evt_tx_th),
    .evt_rx_th(evt_rx_th), .evt_eot(evt_eot), .spi_irq(spi_irq)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          waits;
    bit          is_rd;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] tx_exp_q[$];

  int n_vec = 0;
  int n_mis = 0;
  int tx_beats = 0;
  int rx_beats = 0;
  int wr_pulses = 0;
  int other_pulses = 0;
  int div_pulses = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // One APB transfer: expectation pushed at issue, popped and compared on completion.
  task automatic apb_op(input string tag, input bit wr, input logic [11:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input bit exp_err, input int exp_waits, input bit eot_pulse);
    exp_t        e;
    logic [31:0] rd_obs;
    logic        err_obs;
    int          waits;
    bit          done;
    e.tag = tag; e.rdata = exp_rd; e.err = exp_err; e.waits = exp_waits; e.is_rd = !wr;
    sb_q.push_back(e);
    rd_obs = '0; err_obs = 1'b0; waits = 0; done = 1'b0;
    @(posedge HCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    evt_eot = eot_pulse;
    while (!done && waits <= 50) begin
      @(negedge HCLK);
      if (PREADY) begin
        rd_obs = PRDATA; err_obs = PSLVERR; done = 1'b1;
      end else begin
        waits++;
      end
    end
    if (!done) check_val({tag, "_pready_timeout"}, 32'(waits), 32'(exp_waits));
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; evt_eot = 1'b0;
    e = sb_q.pop_front();
    check_val({e.tag, "_err"}, 32'(err_obs), 32'(e.err));
    check_val({e.tag, "_waits"}, 32'(waits), 32'(e.waits));
    if (e.is_rd) check_val({e.tag, "_rdata"}, rd_obs, e.rdata);
  endtask

  task automatic wr_reg(input string tag, input logic [11:0] a, input logic [31:0] d);
    apb_op(tag, 1'b1, a, d, 32'd0, 1'b0, 0, 1'b0);
  endtask

  task automatic rd_reg(input string tag, input logic [11:0] a, input logic [31:0] exp);
    apb_op(tag, 1'b0, a, 32'd0, exp, 1'b0, 0, 1'b0);
  endtask

  // FIFO-side and pulse monitor.
  initial begin
    forever begin
      @(negedge HCLK);
      if (spi_data_tx_valid && spi_data_tx_ready) begin
        tx_beats++;
        if (tx_exp_q.size() == 0) check_val("tx_beat_unexpected", 32'(tx_exp_q.size()), 32'd1);
        else check_val("tx_data", spi_data_tx, tx_exp_q.pop_front());
      end
      if (spi_data_rx_valid && spi_data_rx_ready) rx_beats++;
      if (spi_wr) wr_pulses++;
      if (spi_rd || spi_qrd || spi_qwr || spi_swrst) other_pulses++;
      if (spi_clk_div_valid) div_pulses++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    HRESETn = 1'b0; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    spi_status = 32'hA5A5_0001; spi_data_tx_ready = 1'b0; spi_data_rx = '0;
    spi_data_rx_valid = 1'b0; evt_tx_th = 1'b0; evt_rx_th = 1'b0; evt_eot = 1'b0;
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;

    // Reset state
    @(negedge HCLK);
    check_val("rst_irq", 32'(spi_irq), 32'd0);
    check_val("rst_pready", 32'(PREADY), 32'd1);
    check_val("rst_csreg", 32'(spi_csreg), 32'd0);
    rd_reg("rst_ctrl",   12'h000, 32'hA5A5_0001);
    rd_reg("rst_clkdiv", 12'h004, 32'd0);
    rd_reg("rst_cmd",    12'h008, 32'd0);
    rd_reg("rst_addr",   12'h00C, 32'd0);
    rd_reg("rst_len",    12'h010, 32'd0);
    rd_reg("rst_dum",    12'h014, 32'd0);
    rd_reg("rst_intcfg", 12'h024, 32'd0);
    rd_reg("rst_intsta", 12'h028, 32'd0);

    // Plain registers
    wr_reg("len_wr", 12'h010, 32'h0040_0820);
    check_val("cmd_len", 32'(spi_cmd_len), 32'h20);
    check_val("addr_len", 32'(spi_addr_len), 32'h08);
    check_val("data_len", 32'(spi_data_len), 32'h40);
    rd_reg("len_rd", 12'h010, 32'h0040_0820);
    wr_reg("ctrl_wr", 12'h000, 32'h0000_0202);
    repeat (3) @(negedge HCLK);
    check_val("wr_pulse_cycles", 32'(wr_pulses), 32'd1);
    check_val("other_pulse_cycles", 32'(other_pulses), 32'd0);
    check_val("csreg", 32'(spi_csreg), 32'h2);
    wr_reg("clkdiv_wr", 12'h004, 32'hABCD_1357);
    repeat (2) @(negedge HCLK);
    check_val("clkdiv_pin", 32'(spi_clk_div), 32'h1357);
    check_val("clkdiv_valid_cycles", 32'(div_pulses), 32'd1);
    rd_reg("clkdiv_rd", 12'h004, 32'h0000_1357);
    wr_reg("cmd_wr", 12'h008, 32'hCAFE_0001);
    rd_reg("cmd_rd", 12'h008, 32'hCAFE_0001);
    wr_reg("addr_wr", 12'h00C, 32'h8765_4321);
    check_val("addr_pin", spi_addr, 32'h8765_4321);
    wr_reg("dum_wr", 12'h014, 32'h0011_0022);
    check_val("dummy_rd", 32'(spi_dummy_rd), 32'h22);
    check_val("dummy_wr", 32'(spi_dummy_wr), 32'h11);

    // TX with 5 stall cycles
    b0 = tx_beats;
    tx_exp_q.push_back(32'hDEAD_BEEF);
    fork
      apb_op("tx_stall", 1'b1, 12'h018, 32'hDEAD_BEEF, 32'd0, 1'b0, 5, 1'b0);
      begin
        int k = 0;
        while (!(PSEL && PENABLE) && k < 20) begin
          @(negedge HCLK);
          k++;
        end
        repeat (4) @(negedge HCLK);
        @(posedge HCLK); #1;
        spi_data_tx_ready = 1'b1;
      end
    join
    check_val("tx_stall_beats", 32'(tx_beats - b0), 32'd1);
    tx_exp_q.push_back(32'h0102_0304);
    apb_op("tx_fast", 1'b1, 12'h018, 32'h0102_0304, 32'd0, 1'b0, 0, 1'b0);
    check_val("tx_total_beats", 32'(tx_beats - b0), 32'd2);
    check_val("tx_exp_left", 32'(tx_exp_q.size()), 32'd0);
    spi_data_tx_ready = 1'b0;

    // RX timeout
    b0 = rx_beats;
    apb_op("rx_timeout", 1'b0, 12'h020, 32'd0, 32'd0, 1'b1, ST, 1'b0);
    check_val("irq_same_cycle", 32'(spi_irq), 32'd0);
    @(posedge HCLK); #1;
    check_val("irq_after_timeout", 32'(spi_irq), 32'd1);
    check_val("rx_timeout_beats", 32'(rx_beats - b0), 32'd0);
    rd_reg("intsta_timeout", 12'h028, 32'h8);
    wr_reg("intsta_clr8", 12'h028, 32'h8);
    rd_reg("intsta_cleared", 12'h028, 32'h0);
    check_val("irq_cleared", 32'(spi_irq), 32'd0);

    // RX zero-wait
    spi_data_rx = 32'h5A5A_1234; spi_data_rx_valid = 1'b1;
    apb_op("rx_fast", 1'b0, 12'h020, 32'd0, 32'h5A5A_1234, 1'b0, 0, 1'b0);
    check_val("rx_fast_beats", 32'(rx_beats - b0), 32'd1);
    spi_data_rx_valid = 1'b0;

    // Interrupts
    wr_reg("intcfg_wr", 12'h024, 32'h0004_0A03);
    check_val("th_tx", 32'(spi_int_th_tx), 32'h3);
    check_val("th_rx", 32'(spi_int_th_rx), 32'hA);
    rd_reg("intcfg_rd", 12'h024, 32'h0004_0A03);
    @(posedge HCLK); #1 evt_tx_th = 1'b1;
    @(posedge HCLK); #1 evt_tx_th = 1'b0;
    rd_reg("intsta_txth", 12'h028, 32'h1);
    check_val("irq_txth_masked", 32'(spi_irq), 32'd0);
    wr_reg("intsta_clr1", 12'h028, 32'h1);
    @(posedge HCLK); #1 evt_eot = 1'b1;
    @(posedge HCLK); #1 evt_eot = 1'b0;
    rd_reg("intsta_eot", 12'h028, 32'h4);
    check_val("irq_eot", 32'(spi_irq), 32'd1);
    apb_op("w1c_race", 1'b1, 12'h028, 32'h4, 32'd0, 1'b0, 0, 1'b1);
    rd_reg("intsta_race", 12'h028, 32'h4);
    check_val("irq_race", 32'(spi_irq), 32'd1);
    wr_reg("intsta_clr4", 12'h028, 32'h4);
    rd_reg("intsta_eot_clr", 12'h028, 32'h0);
    @(posedge HCLK); #1;
    check_val("irq_eot_clr", 32'(spi_irq), 32'd0);

    // Error responses
    spi_data_tx_ready = 1'b1;
    apb_op("err_wr_1c", 1'b1, 12'h01C, 32'hFFFF_FFFF, 32'd0, 1'b1, 0, 1'b0);
    apb_op("err_wr_2c", 1'b1, 12'h02C, 32'hFFFF_FFFF, 32'd0, 1'b1, 0, 1'b0);
    apb_op("err_rd_2c", 1'b0, 12'h02C, 32'd0, 32'd0, 1'b1, 0, 1'b0);
    apb_op("err_rd_tx", 1'b0, 12'h018, 32'd0, 32'd0, 1'b1, 0, 1'b0);
    spi_data_rx_valid = 1'b1;
    apb_op("err_wr_rx", 1'b1, 12'h020, 32'h1234_5678, 32'd0, 1'b1, 0, 1'b0);
    spi_data_rx_valid = 1'b0;
    spi_data_tx_ready = 1'b0;
    check_val("err_rx_beats", 32'(rx_beats - b0), 32'd1);
    rd_reg("err_cmd_kept", 12'h008, 32'hCAFE_0001);
    rd_reg("err_intsta_kept", 12'h028, 32'h0);
    check_val("err_wr_pulses", 32'(wr_pulses), 32'd1);
    check_val("err_other_pulses", 32'(other_pulses), 32'd0);

    // Reset while stalled
    b0 = tx_beats;
    @(posedge HCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h018; PWDATA = 32'h1111_1111;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    repeat (3) @(negedge HCLK);
    check_val("stall_pready_low", 32'(PREADY), 32'd0);
    #1;
    HRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    #1;
    check_val("rst_stall_pready", 32'(PREADY), 32'd1);
    check_val("rst_stall_valid", 32'(spi_data_tx_valid), 32'd0);
    check_val("rst_stall_datalen", 32'(spi_data_len), 32'd0);
    @(posedge HCLK); #1 HRESETn = 1'b1;
    rd_reg("rst_stall_cmd", 12'h008, 32'd0);
    check_val("rst_stall_beats", 32'(tx_beats - b0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
